// File: rtl/vga_timing_gen.sv
// Raster timing generator in the pixel-clock domain: sync/active/coordinate outputs
// plus a one-line-ahead fetch request with outstanding/underflow tracking.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          clock_areset_n,
  input  logic          run,
  input  logic          line_ack,
  input  logic          underflow_clear,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          line_req,
  output logic [YW-1:0] line_req_index,
  output logic          req_pending,
  output logic          underflow
);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = 1'(HSYNC_POL);
  localparam logic          VS_ON    = 1'(VSYNC_POL);

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d, nv;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          active_q, active_d, frame_start_q, frame_start_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d, line_req_index_q, line_req_index_d;
  logic          line_req_q, line_req_d;
  logic          req_pending_q, req_pending_d, underflow_q, underflow_d;
  logic          underflow_set;

  always_comb begin
    nv = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    h_d = '0;
    v_d = '0;
    if (run) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = nv;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  // Outputs are decoded from the current counters, so they lag h/v by one clock.
  always_comb begin
    hsync_d          = ~HS_ON;
    vsync_d          = ~VS_ON;
    active_d         = 1'b0;
    frame_start_d    = 1'b0;
    line_req_d       = 1'b0;
    x_d              = '0;
    y_d              = '0;
    if (run) begin
      hsync_d       = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_ON : ~HS_ON;
      vsync_d       = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_ON : ~VS_ON;
      active_d      = (h_q < H_ACT) && (v_q < V_ACT);
      frame_start_d = (h_q == '0) && (v_q == '0);
      line_req_d    = (h_q == H_ACT) && (nv < V_ACT);
      x_d           = h_q;
      y_d           = v_q;
    end
    line_req_index_d = line_req_d ? nv : line_req_index_q;
  end

  // Request/ack handshake: line_req is a one-cycle request pulse; line_ack is a
  // one-cycle completion pulse that retires whatever request is outstanding. Both
  // are evaluated on the same edge; an ack arriving with a new request retires the
  // old one, so the new request stays pending without counting as an underflow.
  always_comb begin
    underflow_set = line_req_q && req_pending_q && !line_ack;
    req_pending_d = req_pending_q;
    if (line_req_q)    req_pending_d = 1'b1;
    else if (line_ack) req_pending_d = 1'b0;
    underflow_d = underflow_set || (underflow_q && !underflow_clear);
  end

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      h_q              <= '0;
      v_q              <= '0;
      hsync_q          <= ~HS_ON;
      vsync_q          <= ~VS_ON;
      active_q         <= 1'b0;
      frame_start_q    <= 1'b0;
      line_req_q       <= 1'b0;
      x_q              <= '0;
      y_q              <= '0;
      line_req_index_q <= '0;
      req_pending_q    <= 1'b0;
      underflow_q      <= 1'b0;
    end else begin
      h_q              <= h_d;
      v_q              <= v_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      active_q         <= active_d;
      frame_start_q    <= frame_start_d;
      line_req_q       <= line_req_d;
      x_q              <= x_d;
      y_q              <= y_d;
      line_req_index_q <= line_req_index_d;
      req_pending_q    <= req_pending_d;
      underflow_q      <= underflow_d;
    end
  end

  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign active         = active_q;
  assign x              = x_q;
  assign y              = y_q;
  assign frame_start    = frame_start_q;
  assign line_req       = line_req_q;
  assign line_req_index = line_req_index_q;
  assign req_pending    = req_pending_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 15x8 raster: linear-position model compared
// every cycle, plus directed geometry, request, handshake and reset checks.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clock = 1'b0;
  logic       clock_areset_n, run, line_ack, underflow_clear;
  logic       hsync, vsync, active, frame_start, line_req, req_pending, underflow;
  logic [3:0] x;
  logic [2:0] y, line_req_index;

  int  checks = 0;
  int  failures = 0;
  bit  cmp_en = 1'b0;
  logic [2:0] exp_q[$];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut (
    .clock(clock), .clock_areset_n(clock_areset_n), .run(run),
    .line_ack(line_ack), .underflow_clear(underflow_clear),
    .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
    .frame_start(frame_start), .line_req(line_req),
    .line_req_index(line_req_index), .req_pending(req_pending),
    .underflow(underflow)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: raster position is a single running pixel count since the origin
  int m_pos, m_outst, m_h, m_v, m_nv;
  logic e_hs, e_vs, e_act, e_fs, e_lr, e_uf;
  logic [3:0] e_x;
  logic [2:0] e_y, e_idx;
  assign m_h  = m_pos % HT;
  assign m_v  = (m_pos / HT) % VT;
  assign m_nv = (m_v + 1) % VT;

  always @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      m_pos <= 0; m_outst <= 0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_act <= 1'b0; e_fs <= 1'b0; e_lr <= 1'b0;
      e_x <= '0; e_y <= '0; e_idx <= '0; e_uf <= 1'b0;
    end else begin
      if (run) begin
        m_pos <= m_pos + 1;
        e_act <= (m_h < HA) && (m_v < VA);
        e_hs  <= !((m_h >= HA + HF) && (m_h < HA + HF + HS));
        e_vs  <= !((m_v >= VA + VF) && (m_v < VA + VF + VS));
        e_x   <= 4'(m_h);
        e_y   <= 3'(m_v);
        e_fs  <= (m_h == 0) && (m_v == 0);
        e_lr  <= (m_h == HA) && (m_nv < VA);
        if ((m_h == HA) && (m_nv < VA)) e_idx <= 3'(m_nv);
      end else begin
        m_pos <= 0;
        e_act <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1; e_x <= '0; e_y <= '0;
        e_fs <= 1'b0; e_lr <= 1'b0;
      end
      if (line_ack)  m_outst <= e_lr ? 1 : 0;
      else if (e_lr) m_outst <= m_outst + 1;
      if (e_lr && !line_ack && (m_outst > 0)) e_uf <= 1'b1;
      else if (underflow_clear)               e_uf <= 1'b0;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clock) begin
    if (cmp_en)
      check("cycle",
            {hsync, vsync, active, x, y, frame_start, line_req, line_req_index, req_pending, underflow},
            {e_hs, e_vs, e_act, e_x, e_y, e_fs, e_lr, e_idx, (m_outst > 0), e_uf});
  end

  // driver tasks
  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!line_req && n < 200);
    check("req_wait", line_req, 1);
  endtask

  task automatic wait_y(input int yy);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (int'(y) != yy && n < 200);
    check("y_wait", y, yy);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sync"}, {hsync, vsync}, 2'b11);
    check({tag, "_flags"}, {active, frame_start, line_req, req_pending, underflow}, 0);
    check({tag, "_xy"}, {x, y, line_req_index}, 0);
  endtask

  initial begin
    int hs_low, hs_bad, vs_low, vs_bad, act_cnt, pend_cnt, lr_cnt, fs_cnt, ack_at;
    clock_areset_n = 1'b0; run = 1'b0; line_ack = 1'b0; underflow_clear = 1'b0;
    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    check_reset_vals("rst");

    run = 1'b1; clock_areset_n = 1'b1;
    @(negedge clock);
    check("first_active", active, 1);
    check("first_xy", {x, y}, 0);
    check("first_fs", frame_start, 1);

    // frame 1: geometry, request order, ack five cycles after each request
    hs_low = 0; hs_bad = 0; vs_low = 0; vs_bad = 0; act_cnt = 0; pend_cnt = 0;
    lr_cnt = 0; fs_cnt = 0; ack_at = -1;
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 120; i++) begin
      if (i > 0) @(negedge clock);
      line_ack = (i == ack_at);
      if (!hsync) begin hs_low++; if (x < 10 || x > 12) hs_bad++; end
      if (!vsync) begin vs_low++; if (y < 5 || y > 6) vs_bad++; end
      if (active) act_cnt++;
      if (req_pending) pend_cnt++;
      if (frame_start) fs_cnt++;
      if (line_req) begin
        lr_cnt++;
        ack_at = i + 5;
        if (exp_q.size() > 0) check("lr_index", line_req_index, exp_q.pop_front());
        if (line_req_index == 3'd0) check("idx0_pos", {x, y}, {4'd8, 3'd7});
      end
    end
    check("lr_count", lr_cnt, 4);
    check("hs_low", hs_low, 24);
    check("hs_x", hs_bad, 0);
    check("vs_low", vs_low, 30);
    check("vs_y", vs_bad, 0);
    check("active_cnt", act_cnt, 32);
    check("pend_cnt", pend_cnt, 20);
    check("fs_cnt", fs_cnt, 1);
    @(negedge clock);
    line_ack = 1'b0;
    check("fs_period", frame_start, 1);
    check("ack_uf", underflow, 0);

    // frame 2: ack lands in the same cycle as each new request
    for (int i = 1; i < 120; i++) begin
      @(negedge clock);
      line_ack = line_req;
    end
    check("same_pend", req_pending, 1);
    check("same_uf", underflow, 0);

    // underflow: retire the outstanding request, then withhold acks
    @(negedge clock); line_ack = 1'b1;
    @(negedge clock); line_ack = 1'b0;
    check("ack_only", req_pending, 0);
    wait_req();
    @(negedge clock);
    check("uf_first", underflow, 0);
    wait_req();
    @(negedge clock);
    check("uf_set", underflow, 1);
    underflow_clear = 1'b1;
    @(negedge clock); underflow_clear = 1'b0;
    check("uf_clear", underflow, 0);
    wait_req();
    underflow_clear = 1'b1;
    @(negedge clock); underflow_clear = 1'b0;
    check("uf_set_wins", underflow, 1);

    // run drop mid-frame, ack while idle, restart
    wait_y(2);
    run = 1'b0;
    @(negedge clock);
    check("idle_out", {active, hsync, vsync, frame_start, line_req}, 5'b01100);
    check("idle_xy", {x, y}, 0);
    check("idle_uf", underflow, 1);
    line_ack = 1'b1;
    @(negedge clock); line_ack = 1'b0;
    check("idle_ack", req_pending, 0);
    run = 1'b1;
    @(negedge clock);
    check("restart_fs", frame_start, 1);
    check("restart_xy", {x, y}, 0);

    // asynchronous reset mid-line, checked before any clock edge
    repeat (20) @(negedge clock);
    #2 clock_areset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    repeat (3) @(negedge clock);
    clock_areset_n = 1'b1;
    repeat (20) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
